// File: rtl/fmul_pkg.sv
// Shared definitions for the fmul issue/retire sequencer: FSM states,
// IEEE exception flag bit positions and the default multiplier latency.
package fmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CAPT  = 2'd3
  } fmul_state_t;

  localparam int FLAG_W      = 5;
  localparam int FLAG_NV     = 4;
  localparam int FLAG_OF     = 2;
  localparam int FLAG_UF     = 1;
  localparam int FLAG_NX     = 0;
  localparam int LAT_DEFAULT = 5;

endpackage

// File: rtl/fmul_seq_fifo.sv
// Synchronous operand FIFO; storage is not reset, only pointers and count.
// A push while full is dropped even if a pop happens in the same cycle.
module fmul_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count != (AW+1)'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fmul_seq.sv
// Issue/retire sequencer around the iterative multiplier: buffers operands,
// issues one-cycle requests, captures results into a valid/ready register.
module fmul_seq
  import fmul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4,
  parameter int LAT   = LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_x,
  input  logic [31:0]       in_y,
  input  logic [TAGW-1:0]   in_tag,
  output logic              mul_req,
  output logic [31:0]       mul_x,
  output logic [31:0]       mul_y,
  input  logic [31:0]       mul_rslt,
  input  logic [FLAG_W-1:0] mul_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rslt,
  output logic [FLAG_W-1:0] out_flag,
  output logic [TAGW-1:0]   out_tag,
  output logic [FLAG_W-1:0] fflags,
  input  logic              fflags_clr,
  output logic              busy
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int ENT_W = 64 + TAGW;

  fmul_state_t              state;
  fmul_state_t              state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [TAGW-1:0]          tag_q;
  logic [ENT_W-1:0]         fifo_rdata;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     slot_free;
  logic                     capture;

  assign in_ready   = (fifo_count != ($clog2(DEPTH)+1)'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid && in_ready;
  assign slot_free  = !out_valid || out_ready;
  assign capture    = (state == ST_CAPT) && slot_free;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  fmul_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({in_x, in_y, in_tag}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cnt == CNT_W'(LAT - 1)) state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        // An occupied slot parks here; fmul holds rslt until its next req
        if (slot_free) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mul_req   <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      tag_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_rslt  <= '0;
      out_flag  <= '0;
      out_tag   <= '0;
      fflags    <= '0;
    end else begin
      state   <= state_nxt;
      mul_req <= pop;
      // Operands only move on a pop, so they are stable from req to capture
      if (pop) {mul_x, mul_y, tag_q} <= fifo_rdata;
      if (state == ST_ISSUE)     cnt <= '0;
      else if (state == ST_WAIT) cnt <= cnt + 1'b1;
      if (capture) begin
        out_valid <= 1'b1;
        out_rslt  <= mul_rslt;
        out_flag  <= mul_flag;
        out_tag   <= tag_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A clear coinciding with a capture drops old flags but keeps the new ones
      if (capture)         fflags <= (fflags_clr ? '0 : fflags) | mul_flag;
      else if (fflags_clr) fflags <= '0;
    end
  end

endmodule
